// File: rtl/venc_pkg.sv
// Shared constants and types for the rate-1/2, K=3 convolutional encoder
// frame controller.
package venc_pkg;

  localparam int unsigned K        = 3;
  localparam int unsigned TAIL_LEN = K - 1;

  // Generator taps, bit order {x0,x1,x2}: bit K-1 is the newest input bit.
  localparam logic [K-1:0] G0_DEF = 3'b111;
  localparam logic [K-1:0] G1_DEF = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL,
    FIN
  } venc_state_e;

  // Modulo-2 sum of the tapped shift-register bits.
  function automatic logic parity(input logic [K-1:0] x, input logic [K-1:0] g);
    return ^(x & g);
  endfunction

endpackage

// File: rtl/vencoder_frame_ctrl_if.sv
// Information-bit input stream and code-bit output stream of the frame
// controller.
//   in_valid/in_bit/in_ready     : information bit handshake (source -> ctrl)
//   out_valid/out_bit/out_ready  : code bit handshake (ctrl -> serializer)
//   out_sof/out_eof              : first/last code bit of a frame
// master = bit source and downstream sink side, slave = controller side.
interface vencoder_frame_ctrl_if;

  logic in_valid;
  logic in_bit;
  logic in_ready;
  logic out_valid;
  logic out_bit;
  logic out_ready;
  logic out_sof;
  logic out_eof;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_bit, out_sof, out_eof
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_bit, out_sof, out_eof
  );

endinterface

// File: rtl/venc_shift_core.sv
// Encoder shift register with synchronous clear and shift enable.
// Ports:
//   clock, reset (async active-low)
//   clr      : clear the register to zero on the next edge
//   shift_en : shift din in as the newest bit on the next edge
//   din      : bit to shift in
//   p0_d     : G0 parity of the register's next value
//   p1_d     : G1 parity of the register's next value
// The parities look at the next value so the controller can register the
// code bit in the same cycle the register updates.
module venc_shift_core
  import venc_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic shift_en,
  input  logic din,
  output logic p0_d,
  output logic p1_d
);

  logic [K-1:0] x;
  logic [K-1:0] x_d;

  // Next value: newest bit enters at the top, oldest falls out at bit 0.
  always_comb begin
    x_d = x;
    if (clr) begin
      x_d = '0;
    end else if (shift_en) begin
      x_d = {din, x[K-1:1]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x <= '0;
    end else begin
      x <= x_d;
    end
  end

  assign p0_d = parity(x_d, G0);
  assign p1_d = parity(x_d, G1);

endmodule

// File: rtl/vencoder_frame_ctrl.sv
// Frame sequencer for the rate-1/2, K=3 convolutional encoder. Pulls
// frame_len information bits, emits two code bits per information bit
// (G0 then G1), optionally appends K-1 zero tail bits, marks SOF/EOF and
// pulses done after the last output handshake.
// Ports:
//   clock, reset (async active-low)
//   start, frame_len : frame request, sampled in IDLE only
//   bus              : in/out bit streams (vencoder_frame_ctrl_if.slave)
//   busy             : high outside IDLE
//   done             : one-cycle pulse after the frame's last code bit
// Build option: define VENC_TAIL_EN to append the zero tail and flush the
// encoder to state 00.
module vencoder_frame_ctrl
  import venc_pkg::*;
#(
  parameter int unsigned  LEN_W = 16,
  parameter logic [K-1:0] G0    = G0_DEF,
  parameter logic [K-1:0] G1    = G1_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_W-1:0]     frame_len,
  vencoder_frame_ctrl_if.slave bus,
  output logic                 busy,
  output logic                 done
);

`ifdef VENC_TAIL_EN
  localparam bit TAIL_EN = 1'b1;
`else
  localparam bit TAIL_EN = 1'b0;
`endif

  venc_state_e      state, state_d;
  logic [LEN_W-1:0] cnt, cnt_d;
  logic             phase, phase_d;
  logic             sof_pend, sof_pend_d;
  logic             ov_q, ov_d;
  logic             ob_q, ob_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             done_d;

  logic slot_free, hs, in_rdy_c;
  logic data_take, tail_entry, tail_take, take, din;
  logic last_seg, frame_end, clr;
  logic p0_d, p1_d;

  // Output slot is free when empty or when the G1 bit leaves this cycle.
  assign slot_free = !ov_q || (phase && bus.out_ready);
  assign hs        = ov_q && bus.out_ready;
  assign in_rdy_c  = (state == DATA) && (cnt != '0) && slot_free;

  // First tail bit is injected in the same cycle as the last data G1
  // handshake so the tail keeps the one-bit-per-two-cycles cadence.
  assign data_take  = in_rdy_c && bus.in_valid;
  assign tail_entry = TAIL_EN && (state == DATA) && (cnt == '0) && hs && phase;
  assign tail_take  = TAIL_EN && (state == TAIL) && (cnt != '0) && slot_free;
  assign take       = data_take || tail_entry || tail_take;
  assign din        = data_take ? bus.in_bit : 1'b0;

  // Segment whose final G1 bit carries EOF and ends the frame.
  assign last_seg  = TAIL_EN ? (state == TAIL) : (state == DATA);
  assign frame_end = last_seg && (cnt == '0) && hs && phase;
  assign clr       = (state == IDLE) && start && (frame_len != '0);

  venc_shift_core #(
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .clock    (clock),
    .reset    (reset),
    .clr      (clr),
    .shift_en (take),
    .din      (din),
    .p0_d     (p0_d),
    .p1_d     (p1_d)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    phase_d    = phase;
    sof_pend_d = sof_pend;
    ov_d       = ov_q;
    ob_d       = ob_q;
    sof_d      = sof_q;
    eof_d      = eof_q;
    done_d     = 1'b0;

    case (state)
      IDLE: begin
        if (clr) begin
          state_d    = DATA;
          cnt_d      = frame_len;
          phase_d    = 1'b0;
          sof_pend_d = 1'b1;
        end
      end

      DATA, TAIL: begin
        if (take) begin
          ov_d       = 1'b1;
          phase_d    = 1'b0;
          ob_d       = p0_d;
          sof_d      = sof_pend;
          eof_d      = 1'b0;
          sof_pend_d = 1'b0;
          if (tail_entry) begin
            state_d = TAIL;
            cnt_d   = LEN_W'(TAIL_LEN - 1);
          end else begin
            cnt_d = cnt - 1'b1;
          end
        end else if (hs && !phase) begin
          phase_d = 1'b1;
          ob_d    = p1_d;
          sof_d   = 1'b0;
          eof_d   = last_seg && (cnt == '0);
        end else if (hs) begin
          ov_d    = 1'b0;
          phase_d = 1'b0;
          ob_d    = 1'b0;
          sof_d   = 1'b0;
          eof_d   = 1'b0;
          if (frame_end) begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      phase    <= 1'b0;
      sof_pend <= 1'b0;
      ov_q     <= 1'b0;
      ob_q     <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      phase    <= phase_d;
      sof_pend <= sof_pend_d;
      ov_q     <= ov_d;
      ob_q     <= ob_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      busy     <= (state_d != IDLE);
      done     <= done_d;
    end
  end

  assign bus.in_ready  = in_rdy_c;
  assign bus.out_valid = ov_q;
  assign bus.out_bit   = ob_q;
  assign bus.out_sof   = sof_q;
  assign bus.out_eof   = eof_q;

endmodule
